// File: rtl/led_pwm_fader.sv
// Eight-channel PWM LED fader: each level ramps toward 255*PAT_IN[i] by STEP once per fade interval.
// LED_OUT, FADE_TICK and SETTLED are registered one cycle after the state they are computed from.
module led_pwm_fader #(
   parameter int PRESCALE     = 4,
   parameter int FADE_PERIODS = 2,
   parameter int STEP         = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       EN,
   input  logic [7:0] PAT_IN,
   output logic [7:0] LED_OUT,
   output logic       FADE_TICK,
   output logic       SETTLED
);

   localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_PERIODS - 1);
   localparam logic [7:0]        STEP8     = 8'(STEP);

   logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
   logic [7:0]        pwm_cnt_q, pwm_cnt_d;
   logic [FADE_W-1:0] fade_cnt_q, fade_cnt_d;
   logic [7:0]        level_q [8];
   logic [7:0]        level_d [8];
   logic [7:0]        led_out_q, led_out_d;
   logic              fade_tick_q, fade_tick_d;
   logic              settled_q, settled_d;
   logic              cnt_step, period_end, tick_now;
   logic [8:0]        sum;

   always_comb begin
      cnt_step    = EN && (pre_cnt_q == PRE_LAST);
      period_end  = cnt_step && (pwm_cnt_q == 8'hFF);
      tick_now    = period_end && (fade_cnt_q == FADE_LAST);
      pre_cnt_d   = pre_cnt_q;
      pwm_cnt_d   = pwm_cnt_q;
      fade_cnt_d  = fade_cnt_q;
      led_out_d   = '0;
      settled_d   = 1'b1;
      sum         = '0;
      fade_tick_d = tick_now;

      if (EN) begin
         pre_cnt_d = cnt_step ? '0 : pre_cnt_q + 1'b1;
      end
      if (cnt_step) begin
         pwm_cnt_d = pwm_cnt_q + 8'd1;
      end
      if (period_end) begin
         fade_cnt_d = tick_now ? '0 : fade_cnt_q + 1'b1;
      end

      for (int i = 0; i < 8; i++) begin
         level_d[i] = level_q[i];
         // Level 255 is forced fully on so a settled-on LED never blinks at pwm_cnt 255.
         led_out_d[i] = EN && ((level_q[i] == 8'hFF) || (pwm_cnt_q < level_q[i]));
         if (level_q[i] != (PAT_IN[i] ? 8'hFF : 8'h00)) begin
            settled_d = 1'b0;
         end
         if (tick_now) begin
            if (PAT_IN[i]) begin
               sum        = {1'b0, level_q[i]} + {1'b0, STEP8};
               level_d[i] = sum[8] ? 8'hFF : sum[7:0];
            end else begin
               level_d[i] = (level_q[i] > STEP8) ? (level_q[i] - STEP8) : 8'h00;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         pre_cnt_q   <= '0;
         pwm_cnt_q   <= '0;
         fade_cnt_q  <= '0;
         led_out_q   <= '0;
         fade_tick_q <= 1'b0;
         settled_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            level_q[i] <= '0;
         end
      end else begin
         pre_cnt_q   <= pre_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         fade_cnt_q  <= fade_cnt_d;
         led_out_q   <= led_out_d;
         fade_tick_q <= fade_tick_d;
         settled_q   <= settled_d;
         for (int i = 0; i < 8; i++) begin
            level_q[i] <= level_d[i];
         end
      end
   end

   assign LED_OUT   = led_out_q;
   assign FADE_TICK = fade_tick_q;
   assign SETTLED   = settled_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: two instances (fast STEP=64 and slow STEP=100) checked against
// a count-based reference model plus hand-derived timing and duty expectations.
`timescale 1ns/1ps
module tb_led_pwm_fader;

   localparam int PA = 1, FA = 1, SA = 64;
   localparam int PB = 4, FB = 2, SB = 100;
   localparam int PRE  [2] = '{PA, PB};
   localparam int FPER [2] = '{FA, FB};
   localparam int STP  [2] = '{SA, SB};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] pat;
   logic [7:0] led_a, led_b;
   logic       tick_a, tick_b, set_a, set_b;

   int errors = 0;
   int checks = 0;

   int         en_cyc [2];
   int         lvl    [2][8];
   logic [7:0] e_led  [2];
   logic       e_tick [2];
   logic       e_set  [2];

   always #5 clk = ~clk;

   led_pwm_fader #(.PRESCALE(PA), .FADE_PERIODS(FA), .STEP(SA)) dut_a (
      .CLK(clk), .RST_N(rst_n), .EN(en), .PAT_IN(pat),
      .LED_OUT(led_a), .FADE_TICK(tick_a), .SETTLED(set_a));

   led_pwm_fader #(.PRESCALE(PB), .FADE_PERIODS(FB), .STEP(SB)) dut_b (
      .CLK(clk), .RST_N(rst_n), .EN(en), .PAT_IN(pat),
      .LED_OUT(led_b), .FADE_TICK(tick_b), .SETTLED(set_b));

   // Reference: PWM position and tick timing derived from the count of enabled cycles.
   always @(posedge clk) begin : model
      int interval;
      int pos;
      for (int x = 0; x < 2; x++) begin
         interval = 256 * PRE[x] * FPER[x];
         pos      = (en_cyc[x] / PRE[x]) % 256;
         if (!rst_n) begin
            en_cyc[x] = 0;
            e_led[x]  = '0;
            e_tick[x] = 1'b0;
            e_set[x]  = 1'b0;
            for (int i = 0; i < 8; i++) lvl[x][i] = 0;
         end else begin
            e_set[x] = 1'b1;
            for (int i = 0; i < 8; i++) begin
               e_led[x][i] = en && (lvl[x][i] == 255 || pos < lvl[x][i]);
               if (lvl[x][i] != (pat[i] ? 255 : 0)) e_set[x] = 1'b0;
            end
            e_tick[x] = en && (en_cyc[x] % interval == interval - 1);
            if (e_tick[x]) begin
               for (int i = 0; i < 8; i++) begin
                  if (pat[i]) lvl[x][i] = (lvl[x][i] + STP[x] > 255) ? 255 : lvl[x][i] + STP[x];
                  else        lvl[x][i] = (lvl[x][i] < STP[x]) ? 0 : lvl[x][i] - STP[x];
               end
            end
            if (en) en_cyc[x]++;
         end
      end
   end

   task automatic clock_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) clock_step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      pat   = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         clock_step();
         checks++;
         if ({led_a, tick_a, set_a, led_b, tick_b, set_b} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs cycle=%0d got=%h want=0", c, {led_a, tick_a, set_a, led_b, tick_b, set_b});
         end
      end
      rst_n = 1'b1;
      clock_step();
      checks++;
      if ({set_a, set_b} !== 2'b00) begin
         errors++;
         $display("FAIL settled_after_release_ff got=%b want=00", {set_a, set_b});
      end
      pat = 8'h00;
      clock_step();
      checks++;
      if ({set_a, set_b} !== 2'b11) begin
         errors++;
         $display("FAIL settled_after_release_00 got=%b want=11", {set_a, set_b});
      end
      checks++;
      if ({led_a, tick_a, led_b, tick_b} !== 18'h0) begin
         errors++;
         $display("FAIL idle_after_release got=%h want=0", {led_a, tick_a, led_b, tick_b});
      end
   endtask

   task automatic test_ramp_up();
      int ones    [4] = '{0, 0, 0, 0};
      int exp_on  [4] = '{0, 64, 128, 192};
      int cyc;
      en  = 1'b1;
      pat = 8'h01;
      do_reset();
      for (int k = 1; k <= 1100; k++) begin
         clock_step();
         cyc = k + 1;
         checks++;
         if ({led_a, tick_a, set_a} !== {e_led[0], e_tick[0], e_set[0]}) begin
            errors++;
            $display("FAIL ramp_up_model_a cyc=%0d got=%h want=%h", cyc, {led_a, tick_a, set_a}, {e_led[0], e_tick[0], e_set[0]});
         end
         checks++;
         if ({led_b, tick_b, set_b} !== {e_led[1], e_tick[1], e_set[1]}) begin
            errors++;
            $display("FAIL ramp_up_model_b cyc=%0d got=%h want=%h", cyc, {led_b, tick_b, set_b}, {e_led[1], e_tick[1], e_set[1]});
         end
         checks++;
         if (tick_a !== (cyc == 257 || cyc == 513 || cyc == 769 || cyc == 1025)) begin
            errors++;
            $display("FAIL ramp_up_tick_time cyc=%0d got=%b", cyc, tick_a);
         end
         checks++;
         if (led_a[7:1] !== 7'h0) begin
            errors++;
            $display("FAIL ramp_up_idle_leds cyc=%0d got=%h want=0", cyc, led_a[7:1]);
         end
         if (cyc >= 2 && cyc <= 1025) ones[(cyc - 2) / 256] += int'(led_a[0]);
         if (cyc >= 1026) begin
            checks++;
            if ({led_a[0], set_a} !== 2'b11) begin
               errors++;
               $display("FAIL ramp_up_full_on cyc=%0d got=%b want=11", cyc, {led_a[0], set_a});
            end
         end
      end
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (ones[p] != exp_on[p]) begin
            errors++;
            $display("FAIL ramp_up_duty period=%0d got=%0d want=%0d", p, ones[p], exp_on[p]);
         end
      end
   endtask

   task automatic test_ramp_down();
      int ticks = 0;
      int guard = 0;
      int ones;
      int exp_on [5] = '{2048, 1240, 440, 0, 0};
      en  = 1'b1;
      pat = 8'h01 | 8'($urandom & 32'hFE);
      do_reset();
      while (ticks < 3 && guard < 7000) begin
         clock_step();
         guard++;
         if (tick_b === 1'b1) ticks++;
         checks++;
         if ({led_b, tick_b, set_b} !== {e_led[1], e_tick[1], e_set[1]}) begin
            errors++;
            $display("FAIL ramp_down_up_model_b n=%0d got=%h want=%h", guard, {led_b, tick_b, set_b}, {e_led[1], e_tick[1], e_set[1]});
         end
      end
      checks++;
      if (ticks < 3) begin
         errors++;
         $display("FAIL ramp_down_up_timeout ticks=%0d want=3", ticks);
      end
      pat = 8'h00;
      for (int j = 0; j < 5; j++) begin
         ones = 0;
         for (int c = 1; c <= 2048; c++) begin
            clock_step();
            ones += int'(led_b[0]);
            checks++;
            if ({led_a, tick_a, set_a} !== {e_led[0], e_tick[0], e_set[0]}) begin
               errors++;
               $display("FAIL ramp_down_model_a j=%0d c=%0d got=%h want=%h", j, c, {led_a, tick_a, set_a}, {e_led[0], e_tick[0], e_set[0]});
            end
            checks++;
            if ({led_b, tick_b, set_b} !== {e_led[1], e_tick[1], e_set[1]}) begin
               errors++;
               $display("FAIL ramp_down_model_b j=%0d c=%0d got=%h want=%h", j, c, {led_b, tick_b, set_b}, {e_led[1], e_tick[1], e_set[1]});
            end
         end
         checks++;
         if (tick_b !== 1'b1) begin
            errors++;
            $display("FAIL ramp_down_tick_interval j=%0d got=%b want=1", j, tick_b);
         end
         checks++;
         if (ones != exp_on[j]) begin
            errors++;
            $display("FAIL ramp_down_duty j=%0d got=%0d want=%0d", j, ones, exp_on[j]);
         end
      end
      clock_step();
      checks++;
      if ({set_a, set_b, led_a, led_b} !== {2'b11, 16'h0}) begin
         errors++;
         $display("FAIL ramp_down_settled got=%h want=%h", {set_a, set_b, led_a, led_b}, {2'b11, 16'h0});
      end
   endtask

   task automatic test_en_drop();
      int guard = 0;
      en  = 1'b1;
      pat = 8'hFF;
      do_reset();
      while (tick_b !== 1'b1 && guard < 2100) begin
         clock_step();
         guard++;
      end
      checks++;
      if (tick_b !== 1'b1) begin
         errors++;
         $display("FAIL en_drop_first_tick_timeout got=%b want=1", tick_b);
      end
      // 402 more clocks puts the slow instance at pwm_cnt 100, pre_cnt 2.
      for (int c = 1; c <= 402; c++) begin
         clock_step();
         checks++;
         if ({led_a, tick_a, set_a, led_b, tick_b, set_b} !== {e_led[0], e_tick[0], e_set[0], e_led[1], e_tick[1], e_set[1]}) begin
            errors++;
            $display("FAIL en_drop_pre_model c=%0d got=%h want=%h", c, {led_a, tick_a, set_a, led_b, tick_b, set_b},
                     {e_led[0], e_tick[0], e_set[0], e_led[1], e_tick[1], e_set[1]});
         end
      end
      en = 1'b0;
      for (int c = 1; c <= 50; c++) begin
         pat = 8'($urandom);
         clock_step();
         checks++;
         if ({led_a, tick_a, led_b, tick_b} !== 18'h0) begin
            errors++;
            $display("FAIL en_drop_outputs_off c=%0d got=%h want=0", c, {led_a, tick_a, led_b, tick_b});
         end
         checks++;
         if ({set_a, set_b} !== {e_set[0], e_set[1]}) begin
            errors++;
            $display("FAIL en_drop_settled c=%0d got=%b want=%b", c, {set_a, set_b}, {e_set[0], e_set[1]});
         end
      end
      pat = 8'hFF;
      en  = 1'b1;
      for (int m = 1; m <= 623; m++) begin
         clock_step();
         checks++;
         if (led_b[0] !== (m == 623)) begin
            errors++;
            $display("FAIL en_drop_resume_wrap m=%0d got=%b want=%b", m, led_b[0], (m == 623));
         end
         checks++;
         if ({led_a, tick_a, set_a, led_b, tick_b, set_b} !== {e_led[0], e_tick[0], e_set[0], e_led[1], e_tick[1], e_set[1]}) begin
            errors++;
            $display("FAIL en_drop_resume_model m=%0d got=%h want=%h", m, {led_a, tick_a, set_a, led_b, tick_b, set_b},
                     {e_led[0], e_tick[0], e_set[0], e_led[1], e_tick[1], e_set[1]});
         end
      end
   endtask

   task automatic test_tick_flip();
      int ones = 0;
      logic b3;
      en  = 1'b1;
      pat = 8'h08;
      do_reset();
      for (int k = 1; k <= 1024; k++) begin
         b3  = (k <= 512) || (k == 768);
         pat = (8'($urandom) & 8'hF7) | {4'b0, b3, 3'b0};
         clock_step();
         if (k >= 769) ones += int'(led_a[3]);
         checks++;
         if ({led_a, tick_a, set_a} !== {e_led[0], e_tick[0], e_set[0]}) begin
            errors++;
            $display("FAIL tick_flip_model_a k=%0d got=%h want=%h", k, {led_a, tick_a, set_a}, {e_led[0], e_tick[0], e_set[0]});
         end
         checks++;
         if ({led_b, tick_b, set_b} !== {e_led[1], e_tick[1], e_set[1]}) begin
            errors++;
            $display("FAIL tick_flip_model_b k=%0d got=%h want=%h", k, {led_b, tick_b, set_b}, {e_led[1], e_tick[1], e_set[1]});
         end
      end
      checks++;
      if (ones != 192) begin
         errors++;
         $display("FAIL tick_flip_level3_duty got=%0d want=192", ones);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      en  = 1'b1;
      pat = 8'hFF;
      do_reset();
      while (tick_a !== 1'b1 && guard < 300) begin
         clock_step();
         guard++;
      end
      checks++;
      if (tick_a !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_tick_timeout got=%b want=1", tick_a);
      end
      rst_n = 1'b0;
      clock_step();
      checks++;
      if ({led_a, tick_a, set_a, led_b, tick_b, set_b} !== 20'h0) begin
         errors++;
         $display("FAIL reset_mid_clear got=%h want=0", {led_a, tick_a, set_a, led_b, tick_b, set_b});
      end
      rst_n = 1'b1;
      pat   = 8'h00;
      clock_step();
      checks++;
      if ({set_a, set_b} !== 2'b11) begin
         errors++;
         $display("FAIL reset_mid_levels_zero got=%b want=11", {set_a, set_b});
      end
      for (int k = 2; k <= 300; k++) begin
         pat = 8'($urandom);
         clock_step();
         checks++;
         if (tick_a !== (k == 256)) begin
            errors++;
            $display("FAIL reset_mid_next_tick k=%0d got=%b want=%b", k, tick_a, (k == 256));
         end
         checks++;
         if ({led_a, tick_a, set_a, led_b, tick_b, set_b} !== {e_led[0], e_tick[0], e_set[0], e_led[1], e_tick[1], e_set[1]}) begin
            errors++;
            $display("FAIL reset_mid_model k=%0d got=%h want=%h", k, {led_a, tick_a, set_a, led_b, tick_b, set_b},
                     {e_led[0], e_tick[0], e_set[0], e_led[1], e_tick[1], e_set[1]});
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      pat   = 8'hFF;
      @(negedge clk);
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_en_drop();
      test_tick_flip();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
